uart_tx_fifo: RTL

UART transmit path for the FPGA board: accepts bytes from on-chip logic through a write strobe, buffers them in a small FIFO and serialises them as 8N1 frames on the `tx` line, LSB first. It is the transmit-side counterpart of the receive controller. It uses the same 10-bit `baudselect` divisor convention, where one oversample tick occurs every `baudselect` clocks and one bit lasts 16 ticks. For example, 325 at 50 MHz gives ≈9600 baud.

---
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small FIFO.
// Divisor is latched per frame; each bit lasts 16 oversample ticks of max(baudselect,1) clocks.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] baudselect,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx_busy,
    output logic       tx_done_flag,
    output logic       tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          wr_en;
    logic          pop;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_idx;
    logic [9:0]    baud_lat;
    logic [9:0]    div_cnt;
    logic [3:0]    tick_cnt;
    logic          tick;
    logic          bit_end;

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign wr_en   = tx_wr && !fifo_full;
    assign pop     = (state == IDLE) && !fifo_empty;
    assign tick    = (div_cnt == baud_lat - 10'd1);
    assign bit_end = tick && (tick_cnt == 4'd15);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (wr_en && !pop)
            count_next = count + 1'b1;
        else if (pop && !wr_en)
            count_next = count - 1'b1;
    end

    // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            mem[wr_ptr] <= tx_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            fifo_full  <= (count_next == FULL_CNT);
            fifo_empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_flag <= 1'b0;
            shift_reg    <= '0;
            bit_idx      <= '0;
            baud_lat     <= '0;
            div_cnt      <= '0;
            tick_cnt     <= '0;
        end else begin
            tx_done_flag <= 1'b0;

            if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick)
                    tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        baud_lat  <= (baudselect == '0) ? 10'd1 : baudselect;
                        div_cnt   <= '0;
                        tick_cnt  <= '0;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done_flag <= 1'b1;
                        tx_busy      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
